// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_DONE,
    ST_GUARD
  } uart_tx_state_t;

  // PAR_SEL encodings
  localparam logic [1:0] PAR_ODD   = 2'b00;
  localparam logic [1:0] PAR_EVEN  = 2'b01;
  localparam logic [1:0] PAR_MARK  = 2'b10;
  localparam logic [1:0] PAR_SPACE = 2'b11;

  // Data bits per frame = WLEN_BASE + WLEN
  localparam int WLEN_BASE = 5;

  // Parity bit to put on the line, given the XOR of the transmitted data bits.
  function automatic logic parity_bit(input logic [1:0] sel, input logic acc);
    logic p;
    case (sel)
      PAR_ODD:  p = ~acc;
      PAR_EVEN: p = acc;
      PAR_MARK: p = 1'b1;
      default:  p = 1'b0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: down-counter reloaded at each bit start, bit_end when it hits zero.
// Latency: bit_end is asserted div+1 clocks after load.
// Backpressure: none; the sequencer reloads on every bit_end it consumes.
module uart_baud_gen (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] div,
  output logic        bit_end
);

  logic [15:0] cnt_q;

  // Reload on bit start, otherwise count down and park at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 16'd0;
    end else if (load) begin
      cnt_q <= div;
    end else if (cnt_q != 16'd0) begin
      cnt_q <= cnt_q - 16'd1;
    end
  end

  assign bit_end = (cnt_q == 16'd0);

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: serialises one byte per IDLE visit with configurable frame format.
// Latency: TxDataReady to START is 3 clocks (2-flop sync + accept); all outputs registered.
// Backpressure: TxBusy covers START..GUARD; TxDataReady is only sampled in IDLE.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int DONE_HOLD = 8,
  parameter int GUARD     = 8
) (
  input  logic        UART_CLK,
  input  logic        RESET,
  input  logic        TxDataReady,
  input  logic [7:0]  TxData,
  input  logic        ENABLE,
  input  logic [15:0] BAUD_DIV,
  input  logic [1:0]  WLEN,
  input  logic        PAR_EN,
  input  logic [1:0]  PAR_SEL,
  input  logic        STOP2,
  input  logic        BREAK,
  output logic        TXD,
  output logic        TxBusy,
  output logic        TxDone
);

  localparam int HOLD_W = 8;

  uart_tx_state_t state_q, state_d;

  logic              sync1_q, rdy_s_q;
  logic [7:0]        shift_q, shift_d;
  logic [2:0]        bitcnt_q, bitcnt_d;
  logic              par_q, par_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [1:0]        wlen_q, par_sel_q;
  logic              par_en_q, stop2_q;
  logic [15:0]       div_q;
  logic              txd_q, busy_q, done_q;

  logic              accept, load, bit_end, line_d;
  logic [2:0]        last_bit;
  logic [15:0]       div_sel;

  assign last_bit = 3'(WLEN_BASE - 1) + {1'b0, wlen_q};
  // The accepting edge must load the fresh divisor, not the previous frame's.
  assign div_sel  = accept ? BAUD_DIV : div_q;

  uart_baud_gen u_baud (
    .clk     (UART_CLK),
    .rst     (RESET),
    .load    (load),
    .div     (div_sel),
    .bit_end (bit_end)
  );

  // Ready synchroniser; held empty outside IDLE so a level left high is
  // re-qualified from scratch each IDLE visit (gives the DSP side time to update).
  always_ff @(posedge UART_CLK) begin
    if (RESET || state_q != ST_IDLE) begin
      sync1_q <= 1'b0;
      rdy_s_q <= 1'b0;
    end else begin
      sync1_q <= TxDataReady;
      rdy_s_q <= sync1_q;
    end
  end

  // Frame state, datapath and registered outputs.
  always_ff @(posedge UART_CLK) begin
    if (RESET) begin
      state_q   <= ST_IDLE;
      shift_q   <= 8'd0;
      bitcnt_q  <= 3'd0;
      par_q     <= 1'b0;
      hold_q    <= '0;
      wlen_q    <= 2'd0;
      par_en_q  <= 1'b0;
      par_sel_q <= 2'd0;
      stop2_q   <= 1'b0;
      div_q     <= 16'd0;
      txd_q     <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      bitcnt_q <= bitcnt_d;
      par_q    <= par_d;
      hold_q   <= hold_d;
      if (accept) begin
        wlen_q    <= WLEN;
        par_en_q  <= PAR_EN;
        par_sel_q <= PAR_SEL;
        stop2_q   <= STOP2;
        div_q     <= BAUD_DIV;
      end
      txd_q  <= line_d & ~BREAK;
      busy_q <= (state_d != ST_IDLE);
      done_q <= (state_d == ST_DONE);
    end
  end

  // Next-state, shifter, parity accumulation and line value for the next clock.
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    bitcnt_d = bitcnt_q;
    par_d    = par_q;
    hold_d   = hold_q;
    accept   = 1'b0;
    load     = 1'b0;
    line_d   = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (rdy_s_q && ENABLE) begin
          accept   = 1'b1;
          load     = 1'b1;
          shift_d  = TxData;
          bitcnt_d = 3'd0;
          par_d    = 1'b0;
          state_d  = ST_START;
        end
      end
      ST_START: begin
        if (bit_end) begin
          load    = 1'b1;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          load    = 1'b1;
          par_d   = par_q ^ shift_q[0];
          shift_d = {1'b0, shift_q[7:1]};
          if (bitcnt_q == last_bit) begin
            bitcnt_d = 3'd0;
            state_d  = par_en_q ? ST_PARITY : ST_STOP;
          end else begin
            bitcnt_d = bitcnt_q + 3'd1;
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          load    = 1'b1;
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          // bitcnt marks that the first of two stop bits has been sent
          if (stop2_q && bitcnt_q == 3'd0) begin
            load     = 1'b1;
            bitcnt_d = 3'd1;
          end else begin
            hold_d  = '0;
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (hold_q == HOLD_W'(DONE_HOLD - 1)) begin
          hold_d  = '0;
          state_d = ST_GUARD;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      ST_GUARD: begin
        if (hold_q == HOLD_W'(GUARD - 1)) begin
          hold_d  = '0;
          state_d = ST_IDLE;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    case (state_d)
      ST_START:  line_d = 1'b0;
      ST_DATA:   line_d = shift_d[0];
      ST_PARITY: line_d = parity_bit(par_sel_q, par_d);
      default:   line_d = 1'b1;
    endcase
  end

  assign TXD    = txd_q;
  assign TxBusy = busy_q;
  assign TxDone = done_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl: frame bit patterns, parity, back-to-back, BREAK, reset, config.
// Latency: n/a.
// Backpressure: n/a.
module tb_uart_tx_ctrl;

  logic        clk;
  logic        RESET;
  logic        TxDataReady;
  logic [7:0]  TxData;
  logic        ENABLE;
  logic [15:0] BAUD_DIV;
  logic [1:0]  WLEN;
  logic        PAR_EN;
  logic [1:0]  PAR_SEL;
  logic        STOP2;
  logic        BREAK;
  logic        TXD;
  logic        TxBusy;
  logic        TxDone;

  int n_chk  = 0;
  int n_pass = 0;

  uart_tx_ctrl #(.DONE_HOLD(8), .GUARD(8)) dut (
    .UART_CLK    (clk),
    .RESET       (RESET),
    .TxDataReady (TxDataReady),
    .TxData      (TxData),
    .ENABLE      (ENABLE),
    .BAUD_DIV    (BAUD_DIV),
    .WLEN        (WLEN),
    .PAR_EN      (PAR_EN),
    .PAR_SEL     (PAR_SEL),
    .STOP2       (STOP2),
    .BREAK       (BREAK),
    .TXD         (TXD),
    .TxBusy      (TxBusy),
    .TxDone      (TxDone)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Samples TXD for each listed bit (time order) over cpb clocks per bit.
  task automatic expect_line(input string tag, input string bits, input int cpb);
    for (int b = 0; b < bits.len(); b++) begin
      logic exp_b;
      logic obs_b;
      exp_b = (bits.getc(b) == "1");
      obs_b = exp_b;
      for (int c = 0; c < cpb; c++) begin
        if (TXD !== exp_b) obs_b = TXD;
        tick();
      end
      chk($sformatf("%s bit%0d", tag, b), {31'd0, obs_b}, {31'd0, exp_b});
    end
  endtask

  // Raise ready and check the 3-clock accept latency.
  task automatic start_frame(input string tag, input logic hold);
    TxDataReady = 1'b1;
    tick();
    tick();
    chk({tag, " busy_pre"}, {31'd0, TxBusy}, 32'd0);
    tick();
    chk({tag, " accept"}, {30'd0, TxBusy, TXD}, 32'd2);
    if (!hold) TxDataReady = 1'b0;
  endtask

  // Called at the first clock after the last stop bit.
  task automatic check_done(input string tag);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (!(TxDone === 1'b1 && TxBusy === 1'b1 && TXD === 1'b1)) ok = 1'b0;
      tick();
    end
    chk({tag, " done_hold"}, {31'd0, ok}, 32'd1);
  endtask

  task automatic check_guard(input string tag);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (!(TxDone === 1'b0 && TxBusy === 1'b1 && TXD === 1'b1)) ok = 1'b0;
      tick();
    end
    chk({tag, " guard"}, {31'd0, ok}, 32'd1);
    chk({tag, " busy_fall"}, {31'd0, TxBusy}, 32'd0);
  endtask

  initial begin
    logic ok;
    RESET = 1'b1; TxDataReady = 1'b0; TxData = 8'h00; ENABLE = 1'b1;
    BAUD_DIV = 16'd3; WLEN = 2'd3; PAR_EN = 1'b0; PAR_SEL = 2'd0;
    STOP2 = 1'b0; BREAK = 1'b0;
    tick();
    tick();
    chk("reset outputs", {29'd0, TXD, TxBusy, TxDone}, 32'h4);
    RESET = 1'b0;
    tick();
    chk("idle outputs", {29'd0, TXD, TxBusy, TxDone}, 32'h4);

    // 8N1, 4 clocks per bit, 0xA5
    TxData = 8'hA5;
    start_frame("8n1", 1'b0);
    expect_line("8n1", "0101001011", 4);
    check_done("8n1");
    check_guard("8n1");

    // 7-bit data with every parity mode; bit 7 of 0x83 is neither sent nor counted
    BAUD_DIV = 16'd0; WLEN = 2'd2; PAR_EN = 1'b1; TxData = 8'h83;
    for (int s = 0; s < 4; s++) begin
      PAR_SEL = 2'(s);
      start_frame($sformatf("par%0d", s), 1'b0);
      expect_line($sformatf("par%0d", s), (s % 2 == 0) ? "0110000011" : "0110000001", 1);
      check_done($sformatf("par%0d", s));
      check_guard($sformatf("par%0d", s));
    end

    // Back-to-back with ready held high; data changes after the first accept
    WLEN = 2'd3; PAR_EN = 1'b0; TxData = 8'h11;
    start_frame("b2b1", 1'b1);
    expect_line("b2b1", "0100010001", 1);
    check_done("b2b1");
    TxData = 8'h22;
    check_guard("b2b1");
    start_frame("b2b2", 1'b1);
    expect_line("b2b2", "0010001001", 1);
    TxDataReady = 1'b0;
    check_done("b2b2");
    check_guard("b2b2");
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (TxBusy !== 1'b0 || TXD !== 1'b1) ok = 1'b0;
      tick();
    end
    chk("b2b no third frame", {31'd0, ok}, 32'd1);

    // 5N2 with BREAK pulsed during data
    BAUD_DIV = 16'd1; WLEN = 2'd0; STOP2 = 1'b1; TxData = 8'h1F;
    start_frame("5n2", 1'b0);
    expect_line("5n2 pre", "001111", 1);
    BREAK = 1'b1;
    expect_line("5n2 brk", "1000", 1);
    BREAK = 1'b0;
    expect_line("5n2 rel", "01", 1);
    expect_line("5n2 stop", "1111", 1);
    check_done("5n2");
    check_guard("5n2");

    // Reset during data bit 3, then a clean restart
    BAUD_DIV = 16'd3; WLEN = 2'd3; STOP2 = 1'b0; TxData = 8'hA5;
    start_frame("rst", 1'b0);
    expect_line("rst pre", "0101", 4);
    tick();
    RESET = 1'b1;
    tick();
    chk("rst abort", {29'd0, TXD, TxBusy, TxDone}, 32'h4);
    RESET = 1'b0;
    start_frame("rst again", 1'b0);
    expect_line("rst again", "0101001011", 4);
    check_done("rst again");
    check_guard("rst again");

    // Config change and ENABLE drop mid-frame
    BAUD_DIV = 16'd1; WLEN = 2'd3; PAR_EN = 1'b0; STOP2 = 1'b0; TxData = 8'h3C;
    start_frame("cfg", 1'b0);
    expect_line("cfg pre", "00", 2);
    BAUD_DIV = 16'd5; WLEN = 2'd0; PAR_EN = 1'b1; PAR_SEL = 2'd0; STOP2 = 1'b1;
    ENABLE = 1'b0;
    expect_line("cfg post", "01111001", 2);
    check_done("cfg");
    check_guard("cfg");
    TxDataReady = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (TxBusy !== 1'b0) ok = 1'b0;
      tick();
    end
    chk("cfg disabled hold", {31'd0, ok}, 32'd1);
    ENABLE = 1'b1;
    tick();
    chk("cfg enable accept", {30'd0, TxBusy, TXD}, 32'd2);
    TxDataReady = 1'b0;
    expect_line("cfg new", "000111011", 6);
    check_done("cfg new");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
